// File: rtl/pipe_skid_buffer151.sv
// Two-entry skid buffer: registered in_ready and out_data, one-cycle latency, full throughput.
// Optional saturating stall counter port enabled by `define PIPE_SKID_STALL_CNT_EN.
module pipe_skid_buffer151 #(
  parameter int LENGTH = 151
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LENGTH-1:0]   main_q, main_d;
  logic [LENGTH-1:0]   skid_q, skid_d;
  logic                in_ready_q, in_ready_d;
  logic                in_acc, out_acc;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_acc    = in_valid & in_ready_q;
  assign out_acc   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_acc) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_acc && out_acc) begin
            main_d = in_data;
          end else if (in_acc) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_acc) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move
          if (out_acc) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      stall_cnt_d = 16'h0000;
    end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_buffer151.sv
// Self-checking bench for pipe_skid_buffer151: queue-based reference model, directed cases
// plus randomized handshakes. Stall counter cases run when PIPE_SKID_STALL_CNT_EN is defined.
module tb_pipe_skid_buffer151;

  localparam int LENGTH = 151;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [LENGTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LENGTH-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0]       stall_cnt;
  int unsigned       stall_exp;
`endif

  int checks;
  int failures;
  int xfers;
  logic [LENGTH-1:0] model_q[$];

  pipe_skid_buffer151 #(.LENGTH(LENGTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LENGTH-1:0] rand_data();
    logic [LENGTH-1:0] r;
    r = '0;
    for (int i = 0; i < LENGTH; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  // One clock cycle: drive inputs, compare against the queue model mid-cycle, advance the model.
  task automatic cycle(input logic iv, input logic [LENGTH-1:0] d, input logic ordy, input logic fl);
    int  cnt;
    bit  in_acc, out_acc;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    cnt = model_q.size();
    check("in_ready",  160'(in_ready),  160'(cnt < 2));
    check("out_valid", 160'(out_valid), 160'(cnt > 0));
    check("occupancy", 160'(occupancy), 160'(cnt));
    if (cnt > 0) check("out_data", 160'(out_data), 160'(model_q[0]));
`ifdef PIPE_SKID_STALL_CNT_EN
    check("stall_cnt", 160'(stall_cnt), 160'(stall_exp));
    if (fl) stall_exp = 0;
    else if (cnt > 0 && !ordy && stall_exp < 32'hFFFF) stall_exp++;
`endif
    in_acc  = iv && (cnt < 2);
    out_acc = ordy && (cnt > 0);
    if (fl) begin
      model_q.delete();
    end else begin
      if (out_acc) begin
        xfers++;
        $display("xfer %0d data=%h occ=%0d", xfers, model_q[0], cnt);
        void'(model_q.pop_front());
      end
      if (in_acc) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    xfers     = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef PIPE_SKID_STALL_CNT_EN
    stall_exp = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  160'(in_ready),  160'(1));
    check("rst_out_valid", 160'(out_valid), 160'(0));
    check("rst_occupancy", 160'(occupancy), 160'(0));
    check("rst_out_data",  160'(out_data),  160'(0));
    reset = 1'b1;

    // Streaming at full rate
    for (int k = 1; k <= 4; k++) cycle(1'b1, LENGTH'(k), 1'b1, 1'b0);
    check("stream_out_data", 160'(out_data), 160'(4));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A, B fill the buffer; C is offered while full and must vanish
    cycle(1'b1, LENGTH'(32'hA), 1'b0, 1'b0);
    cycle(1'b1, LENGTH'(32'hB), 1'b0, 1'b0);
    cycle(1'b1, LENGTH'(32'hC), 1'b0, 1'b0);
    check("bp_occupancy", 160'(occupancy), 160'(2));
    check("bp_in_ready",  160'(in_ready),  160'(0));
    check("bp_hold_data", 160'(out_data),  160'(32'hA));
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("bp_second", 160'(out_data), 160'(32'hB));
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush while full with D offered
    cycle(1'b1, LENGTH'(32'h11), 1'b0, 1'b0);
    cycle(1'b1, LENGTH'(32'h22), 1'b0, 1'b0);
    cycle(1'b1, LENGTH'(32'hD),  1'b0, 1'b1);
    check("flush_occupancy", 160'(occupancy), 160'(0));
    check("flush_out_valid", 160'(out_valid), 160'(0));
    check("flush_in_ready",  160'(in_ready),  160'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset while holding two entries
    cycle(1'b1, LENGTH'(32'h33), 1'b0, 1'b0);
    cycle(1'b1, LENGTH'(32'h44), 1'b0, 1'b0);
    check("pre_rst_occupancy", 160'(occupancy), 160'(2));
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", 160'(out_valid), 160'(0));
    check("arst_in_ready",  160'(in_ready),  160'(1));
    check("arst_out_data",  160'(out_data),  160'(0));
    check("arst_occupancy", 160'(occupancy), 160'(0));
    model_q.delete();
`ifdef PIPE_SKID_STALL_CNT_EN
    stall_exp = 0;
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);

`ifdef PIPE_SKID_STALL_CNT_EN
    // Stall counter saturation and clear on flush
    cycle(1'b1, LENGTH'(32'h55), 1'b0, 1'b0);
    for (int k = 0; k < 70000; k++) cycle(1'b0, rand_data(), 1'b0, 1'b0);
    check("stall_sat", 160'(stall_cnt), 160'(16'hFFFF));
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("stall_clr", 160'(stall_cnt), 160'(0));
`endif

    // Random handshakes with occasional flushes
    for (int k = 0; k < 10000; k++) begin
      cycle(1'($urandom), rand_data(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_occupancy", 160'(occupancy), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
